fuzzy_mapping_seq: RTL and testbench
====================================

Name: fuzzy_mapping_seq

Overview:
- Multi-channel sequential fuzzifier for the sensor front end.
- Maps an unsigned input sample onto a per-channel trapezoidal membership function (nodes N0<=N1<=N2<=N3).
- Emits a region flag and a LEVELS-bit thermometer membership code.
- Generalises the combinational trapezoid mapper: runtime-programmable nodes per channel, valid/ready handshakes, and a serial bit-per-cycle encoder instead of a combinational divider.

Parameters:
- IN_W, 4, input sample and node width (unsigned).
- LEVELS, 10, membership resolution = thermometer code width.
- CHANNELS, 2, number of independent node sets.
- NODE0 / NODE1 / NODE2 / NODE3, 0 / 4 / 8 / 12, reset value of every channel's nodes.

Ports:
- Clk, in, 1, system clock, rising edge.
- Reset, in, 1, asynchronous active-high reset.
- CfgWe, in, 1, node write strobe.
- CfgChan, in, max(1,$clog2(CHANNELS)), channel to write.
- CfgNode, in, 2, node index 0..3.
- CfgData, in, IN_W, node value.
- InValid, in, 1, sample valid.
- InReady, out, 1, block can accept a sample.
- InChan, in, max(1,$clog2(CHANNELS)), channel of the sample.
- InFixed, in, IN_W, sample value.
- OutValid, out, 1, result valid.
- OutReady, in, 1, downstream accepts the result.
- OutChan, out, max(1,$clog2(CHANNELS)), channel of the result.
- LocalFlag, out, 3, region flag: [2]=rising, [1]=core, [0]=falling.
- LongBitData, out, LEVELS, thermometer membership code (LSB-first fill).
- OutOfRange, out, 1, sample outside [N0,N3].
- ErrorReturn, out, 1, node ordering invalid for this channel.

Behaviour:
- Reset (async, any state including mid-CALC):
  - state=IDLE; all nodes revert to NODE0..NODE3.
  - OutValid, LocalFlag, LongBitData, OutOfRange, ErrorReturn and OutChan all 0.
  - InReady is 1 once Reset deasserts.
- Config writes:
  - A write on CfgWe takes effect at the clock edge in any state.
  - An accepted sample snapshots its channel's four nodes at the accept edge; later writes do not affect a sample in flight.
  - Write and accept on the same channel in the same cycle: the sample uses the pre-write nodes.
  - CfgChan >= CHANNELS: write ignored.
- FSM:
  - States: IDLE, CALC, DONE. InReady = (state==IDLE).
  - IDLE: on InValid&&InReady, latch x, nodes and channel, then classify.
    - If region is rising or falling: go to CALC, k=1.
    - Otherwise: go to DONE with the result already registered.
  - CALC: one thermometer bit per cycle. Bit k-1 = (num*LEVELS >= k*span).
    - The num*LEVELS product and the accumulated k*span are held in registers of width IN_W+$clog2(LEVELS+1); no overflow is possible.
    - After bit LEVELS-1 is written, go to DONE.
  - DONE: OutValid=1; all outputs held stable while !OutReady. On OutReady, OutValid drops and state returns to IDLE.
- Classification (evaluated in order, first match wins):
  - Nodes not monotonic (N0>N1, N1>N2 or N2>N3): ErrorReturn=1, flags 0, code 0.
  - x<N0 or x>N3: OutOfRange=1, flags 0, code 0.
  - N1<=x<=N2: LocalFlag=3'b010, code all ones. Core wins at both boundaries.
  - N0<=x<N1: LocalFlag=3'b100, num=x-N0, span=N1-N0 (always >0 here).
  - N2<x<=N3: LocalFlag=3'b001, num=N3-x, span=N3-N2 (always >0 here).
- Latency (accept edge to OutValid rising):
  - Core, out-of-range or error: 1 cycle.
  - Rising or falling region: LEVELS+1 cycles.
- Throughput: one sample per (latency+1) cycles minimum; no overlap between samples.
- InChan >= CHANNELS: the sample is accepted and reported as ErrorReturn=1.

Test Plan:
- Reset defaults, channel 0, InFixed=2 -> after 11 cycles: OutValid=1, LocalFlag=100, LongBitData=10'h01F, OutOfRange=0.
- InFixed=6 -> 1 cycle: LocalFlag=010, LongBitData=10'h3FF. InFixed=4 (boundary) -> identical core result.
- InFixed=10 -> 11 cycles: LocalFlag=001, LongBitData=10'h01F. InFixed=12 -> LocalFlag=001, LongBitData=10'h000.
- Program channel 1 nodes {2,3,3,15}, InFixed=1 on channel 1 -> OutOfRange=1, code 0. Write N1=1 on channel 1, InFixed=2 -> ErrorReturn=1.
- Hold OutReady=0 for 5 cycles after OutValid -> outputs and OutChan stable, InReady=0. Raise OutReady -> OutValid=0 and InReady=1 next cycle.
- Assert Reset at CALC cycle 5 -> all outputs 0 immediately, nodes back to defaults. A fresh InFixed=2 after reset reproduces the first scenario.

Source files
------------

// File: rtl/fuzzy_mapping_seq.sv
// fuzzy_mapping_seq
//   Multi-channel sequential trapezoid fuzzifier. Each channel holds four
//   programmable nodes N0<=N1<=N2<=N3. An accepted sample is classified
//   against its channel's nodes. For the rising and falling slopes, a serial
//   encoder produces a LEVELS-bit thermometer code, one bit per cycle.
// Ports:
//   Clk/Reset                     clock, async active-high reset
//   CfgWe/CfgChan/CfgNode/CfgData node write port (any state)
//   InValid/InReady/InChan/InFixed   sample handshake
//   OutValid/OutReady/OutChan        result handshake
//   LocalFlag   {rising,core,falling}
//   LongBitData thermometer membership code, LSB-first fill
//   OutOfRange  sample outside [N0,N3]
//   ErrorReturn non-monotonic nodes or bad channel
module fuzzy_mapping_seq #(
  parameter int IN_W     = 4,
  parameter int LEVELS   = 10,
  parameter int CHANNELS = 2,
  parameter int NODE0    = 0,
  parameter int NODE1    = 4,
  parameter int NODE2    = 8,
  parameter int NODE3    = 12,
  localparam int CW      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              CfgWe,
  input  logic [CW-1:0]     CfgChan,
  input  logic [1:0]        CfgNode,
  input  logic [IN_W-1:0]   CfgData,
  input  logic              InValid,
  output logic              InReady,
  input  logic [CW-1:0]     InChan,
  input  logic [IN_W-1:0]   InFixed,
  output logic              OutValid,
  input  logic              OutReady,
  output logic [CW-1:0]     OutChan,
  output logic [2:0]        LocalFlag,
  output logic [LEVELS-1:0] LongBitData,
  output logic              OutOfRange,
  output logic              ErrorReturn
);

  localparam int KW = $clog2(LEVELS + 1);
  localparam int PW = IN_W + KW;  // holds num*LEVELS and k*span without overflow

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state, stateNext;

  logic [IN_W-1:0] nodes [CHANNELS][4];

  logic [PW-1:0] prod, span, acc;
  logic [KW-1:0] bitIdx;

  // Classification of the incoming sample against the current (pre-write) nodes
  logic              badChan, accept;
  logic [IN_W-1:0]   n0, n1, n2, n3;
  logic [2:0]        cFlag;
  logic [LEVELS-1:0] cCode;
  logic              cErr, cOor, cCalc;
  logic [IN_W-1:0]   cNum, cSpan;

  assign InReady  = (state == IDLE);
  assign OutValid = (state == DONE);
  assign accept   = InValid && InReady;

  always_comb begin
    badChan = (32'(InChan) >= CHANNELS);
    n0 = '0; n1 = '0; n2 = '0; n3 = '0;
    if (!badChan) begin
      n0 = nodes[InChan][0];
      n1 = nodes[InChan][1];
      n2 = nodes[InChan][2];
      n3 = nodes[InChan][3];
    end
    cFlag = 3'b000;
    cCode = '0;
    cErr  = 1'b0;
    cOor  = 1'b0;
    cCalc = 1'b0;
    cNum  = '0;
    cSpan = '0;
    if (badChan || n0 > n1 || n1 > n2 || n2 > n3) begin
      cErr = 1'b1;
    end else if (InFixed < n0 || InFixed > n3) begin
      cOor = 1'b1;
    end else if (InFixed >= n1 && InFixed <= n2) begin
      // core takes both boundaries, so the slopes below never see span==0
      cFlag = 3'b010;
      cCode = '1;
    end else if (InFixed < n1) begin
      cFlag = 3'b100;
      cCalc = 1'b1;
      cNum  = InFixed - n0;
      cSpan = n1 - n0;
    end else begin
      cFlag = 3'b001;
      cCalc = 1'b1;
      cNum  = n3 - InFixed;
      cSpan = n3 - n2;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state <= IDLE;
    else       state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE: if (accept) stateNext = cCalc ? CALC : DONE;
      CALC: if (bitIdx == KW'(LEVELS - 1)) stateNext = DONE;
      DONE: if (OutReady) stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      for (int c = 0; c < CHANNELS; c++) begin
        nodes[c][0] <= IN_W'(NODE0);
        nodes[c][1] <= IN_W'(NODE1);
        nodes[c][2] <= IN_W'(NODE2);
        nodes[c][3] <= IN_W'(NODE3);
      end
      OutChan     <= '0;
      LocalFlag   <= '0;
      LongBitData <= '0;
      OutOfRange  <= 1'b0;
      ErrorReturn <= 1'b0;
      prod        <= '0;
      span        <= '0;
      acc         <= '0;
      bitIdx      <= '0;
    end else begin
      if (CfgWe && 32'(CfgChan) < CHANNELS)
        nodes[CfgChan][CfgNode] <= CfgData;
      if (accept) begin
        // Snapshot: only num*LEVELS and span are kept, so later node
        // writes cannot disturb the sample in flight.
        OutChan     <= InChan;
        LocalFlag   <= cFlag;
        LongBitData <= cCode;
        OutOfRange  <= cOor;
        ErrorReturn <= cErr;
        prod        <= PW'(cNum) * PW'(LEVELS);
        span        <= PW'(cSpan);
        acc         <= PW'(cSpan);
        bitIdx      <= '0;
      end else if (state == CALC) begin
        // bit k-1 = num*LEVELS >= k*span, acc tracks k*span
        LongBitData[bitIdx] <= (prod >= acc);
        acc                 <= acc + span;
        bitIdx              <= bitIdx + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fuzzy_mapping_seq.sv
module tb_fuzzy_mapping_seq;
  localparam int IN_W = 4, LEVELS = 10, CHANNELS = 2, CW = 1;

  logic              Clk = 1'b0, Reset = 1'b1;
  logic              CfgWe = 1'b0;
  logic [CW-1:0]     CfgChan = '0;
  logic [1:0]        CfgNode = '0;
  logic [IN_W-1:0]   CfgData = '0;
  logic              InValid = 1'b0, InReady;
  logic [CW-1:0]     InChan = '0;
  logic [IN_W-1:0]   InFixed = '0;
  logic              OutValid, OutReady = 1'b1;
  logic [CW-1:0]     OutChan;
  logic [2:0]        LocalFlag;
  logic [LEVELS-1:0] LongBitData;
  logic              OutOfRange, ErrorReturn;

  fuzzy_mapping_seq #(.IN_W(IN_W), .LEVELS(LEVELS), .CHANNELS(CHANNELS)) dut (
    .Clk(Clk), .Reset(Reset), .CfgWe(CfgWe), .CfgChan(CfgChan), .CfgNode(CfgNode),
    .CfgData(CfgData), .InValid(InValid), .InReady(InReady), .InChan(InChan),
    .InFixed(InFixed), .OutValid(OutValid), .OutReady(OutReady), .OutChan(OutChan),
    .LocalFlag(LocalFlag), .LongBitData(LongBitData), .OutOfRange(OutOfRange),
    .ErrorReturn(ErrorReturn));

  always #5 Clk = ~Clk;

  typedef struct packed {
    logic [CW-1:0]     chan;
    logic [2:0]        flag;
    logic [LEVELS-1:0] code;
    logic              oor;
    logic              err;
  } exp_t;

  exp_t expQ[$];
  int   checks = 0, errors = 0;

  task automatic check(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Monitor: pops on every completed output handshake
  always @(negedge Clk) begin
    if (!Reset && OutValid && OutReady) begin
      exp_t e;
      if (expQ.size() == 0) begin
        check("unexpected_output", 1, 0);
      end else begin
        e = expQ.pop_front();
        check("OutChan", OutChan, e.chan);
        check("LocalFlag", LocalFlag, e.flag);
        check("LongBitData", LongBitData, e.code);
        check("OutOfRange", OutOfRange, e.oor);
        check("ErrorReturn", ErrorReturn, e.err);
      end
    end
  end

  task automatic cfg(input int ch, input int nd, input int val);
    CfgWe = 1'b1; CfgChan = CW'(ch); CfgNode = 2'(nd); CfgData = IN_W'(val);
    @(posedge Clk); #1;
    CfgWe = 1'b0;
  endtask

  // Issue one sample, push its expectation, measure latency to OutValid.
  // Leaves time at posedge+1 with OutValid high.
  task automatic issue(input int ch, input int x, input exp_t e, input int lat);
    int n;
    check("InReady_before", InReady, 1);
    expQ.push_back(e);
    InValid = 1'b1; InChan = CW'(ch); InFixed = IN_W'(x);
    @(posedge Clk); #1;
    InValid = 1'b0;
    n = 1;
    while (!OutValid && n < 40) begin
      @(posedge Clk); #1; n++;
    end
    check("latency", n, lat);
  endtask

  task automatic drain();
    @(posedge Clk); #1;
    check("OutValid_drop", OutValid, 0);
    check("InReady_after", InReady, 1);
  endtask

  task automatic run(input int ch, input int x, input exp_t e, input int lat);
    issue(ch, x, e, lat);
    drain();
  endtask

  initial begin
    #12;
    check("rst_OutValid", OutValid, 0);
    check("rst_LocalFlag", LocalFlag, 0);
    check("rst_LongBitData", LongBitData, 0);
    check("rst_OutOfRange", OutOfRange, 0);
    check("rst_ErrorReturn", ErrorReturn, 0);
    check("rst_OutChan", OutChan, 0);
    @(negedge Clk); Reset = 1'b0;
    @(posedge Clk); #1;
    check("rst_InReady", InReady, 1);

    // Default nodes 0/4/8/12
    run(0, 2,  '{chan:0, flag:3'b100, code:10'h01F, oor:0, err:0}, 11);
    run(0, 6,  '{chan:0, flag:3'b010, code:10'h3FF, oor:0, err:0}, 1);
    run(0, 4,  '{chan:0, flag:3'b010, code:10'h3FF, oor:0, err:0}, 1);
    run(0, 8,  '{chan:0, flag:3'b010, code:10'h3FF, oor:0, err:0}, 1);
    run(0, 10, '{chan:0, flag:3'b001, code:10'h01F, oor:0, err:0}, 11);
    run(0, 12, '{chan:0, flag:3'b001, code:10'h000, oor:0, err:0}, 11);
    run(0, 0,  '{chan:0, flag:3'b100, code:10'h000, oor:0, err:0}, 11);
    run(0, 13, '{chan:0, flag:3'b000, code:10'h000, oor:1, err:0}, 1);
    // x=11: num=1 span=4 -> 10>=4k for k<=2
    run(0, 11, '{chan:0, flag:3'b001, code:10'h003, oor:0, err:0}, 11);

    // Channel 1 nodes {2,3,3,15}
    cfg(1, 0, 2); cfg(1, 1, 3); cfg(1, 2, 3); cfg(1, 3, 15);
    run(1, 1,  '{chan:1, flag:3'b000, code:10'h000, oor:1, err:0}, 1);
    // x=14: num=1 span=12 -> 10>=12k never
    run(1, 14, '{chan:1, flag:3'b001, code:10'h000, oor:0, err:0}, 11);
    // x=2: num=0 span=1 -> rising, code 0
    run(1, 2,  '{chan:1, flag:3'b100, code:10'h000, oor:0, err:0}, 11);
    cfg(1, 1, 1);
    run(1, 2,  '{chan:1, flag:3'b000, code:10'h000, oor:0, err:1}, 1);
    // Channel 0 untouched by channel-1 writes
    run(0, 2,  '{chan:0, flag:3'b100, code:10'h01F, oor:0, err:0}, 11);

    // Backpressure: hold OutReady low 5 cycles
    OutReady = 1'b0;
    issue(1, 1, '{chan:1, flag:3'b000, code:10'h000, oor:0, err:1}, 1);
    for (int i = 0; i < 5; i++) begin
      @(posedge Clk); #1;
      check("hold_OutValid", OutValid, 1);
      check("hold_InReady", InReady, 0);
      check("hold_OutChan", OutChan, 1);
      check("hold_ErrorReturn", ErrorReturn, 1);
    end
    OutReady = 1'b1;
    drain();

    // Write and accept on the same channel in the same cycle: old nodes used
    check("InReady_samecyc", InReady, 1);
    expQ.push_back('{chan:0, flag:3'b100, code:10'h01F, oor:0, err:0});
    CfgWe = 1'b1; CfgChan = 0; CfgNode = 2'd1; CfgData = 4'd8;
    InValid = 1'b1; InChan = 0; InFixed = 4'd2;
    @(posedge Clk); #1;
    CfgWe = 1'b0; InValid = 1'b0;
    // Mid-flight write must not disturb the sample
    cfg(0, 0, 1);
    begin
      int n = 2;
      while (!OutValid && n < 40) begin @(posedge Clk); #1; n++; end
      check("latency_samecyc", n, 11);
    end
    drain();
    // Now nodes {1,8,8,12}: x=2 num=1 span=7 -> 10>=7k for k=1
    run(0, 2, '{chan:0, flag:3'b100, code:10'h001, oor:0, err:0}, 11);

    // Reset at CALC cycle 5
    InValid = 1'b1; InChan = 0; InFixed = 4'd2;
    @(posedge Clk); #1;
    InValid = 1'b0;
    repeat (5) @(posedge Clk);
    #1 Reset = 1'b1;
    #1;
    check("mid_OutValid", OutValid, 0);
    check("mid_LocalFlag", LocalFlag, 0);
    check("mid_LongBitData", LongBitData, 0);
    check("mid_OutOfRange", OutOfRange, 0);
    check("mid_ErrorReturn", ErrorReturn, 0);
    check("mid_OutChan", OutChan, 0);
    @(negedge Clk); Reset = 1'b0;
    @(posedge Clk); #1;
    check("mid_InReady", InReady, 1);
    run(0, 2, '{chan:0, flag:3'b100, code:10'h01F, oor:0, err:0}, 11);
    // Channel 1 back to defaults: x=1 num=1 span=4 -> k<=2
    run(1, 1, '{chan:1, flag:3'b100, code:10'h003, oor:0, err:0}, 11);

    repeat (2) @(posedge Clk);
    check("queue_empty", expQ.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end
endmodule
